// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and the UART transmitter.
// master: arbiter side; slave: requester/transmitter side.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned IdW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic [NUM_REQ-1:0]   done;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_done;
   logic                 busy;
   logic [IdW-1:0]       grant_id;
   logic                 timeout;

   modport master (
      input  req, req_data, tx_done,
      output ack, done, tx_start, tx_data, busy, grant_id, timeout
   );

   modport slave (
      output req, req_data, tx_done,
      input  ack, done, tx_start, tx_data, busy, grant_id, timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// IDLE picks a requester, LAUNCH pulses tx_start/ack, WAIT holds until tx_done.
// Optional WAIT watchdog compiled in with macro UART_TX_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_tx_arbiter_if.master      bus
);
   localparam int unsigned IdW = $clog2(NUM_REQ);

   // Elaboration-time guard on the legal configuration range.
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_err
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

   state_e             state_q;
   logic [IdW-1:0]     rr_ptr_q;
   logic [IdW-1:0]     grant_id_q;
   logic [7:0]         tx_data_q;
   logic [NUM_REQ-1:0] ack_q;
   logic [NUM_REQ-1:0] done_q;
   logic               tx_start_q;
   logic               busy_q;
   logic               timeout_q;

   logic [IdW-1:0]     pick;
   logic               pick_vld;
   logic [7:0]         pick_data;
   logic [IdW-1:0]     next_ptr;

`ifdef UART_TX_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
   logic [CntW-1:0] cnt_q;
`endif

   // First pending request at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NUM_REQ;
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_vld && (idx == j) && bus.req[j]) begin
               pick     = IdW'(j);
               pick_vld = 1'b1;
            end
         end
      end
   end

   // Byte slice of the picked requester.
   always_comb begin
      pick_data = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (pick == IdW'(j)) pick_data = bus.req_data[8*j +: 8];
      end
   end

   // Pointer moves just past the requester that was last served.
   assign next_ptr = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

   // Arbitration FSM; all outputs are registered and pulses last one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         tx_data_q  <= '0;
         ack_q      <= '0;
         done_q     <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         ack_q      <= '0;
         done_q     <= '0;
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (pick_vld) begin
                  state_q    <= StLaunch;
                  grant_id_q <= pick;
                  tx_data_q  <= pick_data;
                  ack_q      <= NUM_REQ'(1) << pick;
                  tx_start_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            StLaunch: begin
               state_q <= StWait;
`ifdef UART_TX_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            StWait: begin
               // Completion wins over a coincident watchdog expiry.
               if (bus.tx_done) begin
                  state_q  <= StIdle;
                  done_q   <= NUM_REQ'(1) << grant_id_q;
                  rr_ptr_q <= next_ptr;
                  busy_q   <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
               end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  state_q   <= StIdle;
                  timeout_q <= 1'b1;
                  rr_ptr_q  <= next_ptr;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
`endif
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack      = ack_q;
   assign bus.done     = done_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.busy     = busy_q;
   assign bus.grant_id = grant_id_q;
`ifdef UART_TX_TIMEOUT_EN
   assign bus.timeout  = timeout_q;
`else
   assign bus.timeout  = 1'b0;
   logic unused_timeout;
   assign unused_timeout = timeout_q;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int N = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;
   int   ptr_m;
   int   g;
   logic [7:0] eb;
   logic [7:0] bytes_m [N];
   int   rr_exp [5];

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester served next: first pending index counting up from the model pointer.
   function automatic int model_pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[(ptr_m + i) % N]) return (ptr_m + i) % N;
      end
      return -1;
   endfunction

   task automatic drive_data();
      for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = bytes_m[i];
   endtask

   task automatic do_reset(input int cycles);
      bus.req     = '0;
      bus.tx_done = 1'b0;
      reset       = 1'b0;
      #1;
      check_eq("rst_ack", 32'(bus.ack), 0);
      check_eq("rst_done", 32'(bus.done), 0);
      check_eq("rst_start", 32'(bus.tx_start), 0);
      check_eq("rst_data", 32'(bus.tx_data), 0);
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_grant", 32'(bus.grant_id), 0);
      check_eq("rst_timeout", 32'(bus.timeout), 0);
      for (int k = 0; k < cycles; k++) begin
         tick();
         check_eq("rst_hold_done", 32'(bus.done), 0);
         check_eq("rst_hold_busy", 32'(bus.busy), 0);
      end
      reset = 1'b1;
      ptr_m = 0;
   endtask

   // From an IDLE cycle: present r, check LAUNCH, and stop in the first WAIT cycle.
   task automatic start_xfer(input logic [N-1:0] r, output int gg, output logic [7:0] ebb);
      gg  = model_pick(r);
      ebb = (gg >= 0) ? bytes_m[gg] : 8'h00;
      drive_data();
      bus.req     = r;
      bus.tx_done = 1'($urandom_range(0, 1));
      tick();
      bus.tx_done = 1'($urandom_range(0, 1));
      if (gg < 0) begin
         check_eq("idle_busy", 32'(bus.busy), 0);
         check_eq("idle_ack", 32'(bus.ack), 0);
         check_eq("idle_start", 32'(bus.tx_start), 0);
         check_eq("idle_done", 32'(bus.done), 0);
         return;
      end
      check_eq("launch_ack", 32'(bus.ack), 32'(1) << gg);
      check_eq("launch_start", 32'(bus.tx_start), 1);
      check_eq("launch_data", 32'(bus.tx_data), 32'(ebb));
      check_eq("launch_grant", 32'(bus.grant_id), 32'(gg));
      check_eq("launch_busy", 32'(bus.busy), 1);
      check_eq("launch_done", 32'(bus.done), 0);
      check_eq("launch_timeout", 32'(bus.timeout), 0);
      bus.req      = N'($urandom);
      bus.req_data = '1;
      tick();
      bus.tx_done = 1'b0;
   endtask

   // From WAIT cycle 0: idle w cycles, pulse tx_done, check the done cycle.
   task automatic finish_xfer(input int gg, input logic [7:0] ebb, input int w);
      for (int k = 0; k < w; k++) begin
         check_eq("wait_busy", 32'(bus.busy), 1);
         check_eq("wait_ack", 32'(bus.ack), 0);
         check_eq("wait_done", 32'(bus.done), 0);
         check_eq("wait_start", 32'(bus.tx_start), 0);
         check_eq("wait_data", 32'(bus.tx_data), 32'(ebb));
         check_eq("wait_timeout", 32'(bus.timeout), 0);
         bus.req = N'($urandom);
         tick();
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      check_eq("done_vec", 32'(bus.done), 32'(1) << gg);
      check_eq("done_ack", 32'(bus.ack), 0);
      check_eq("done_start", 32'(bus.tx_start), 0);
      check_eq("done_busy", 32'(bus.busy), 0);
      check_eq("done_timeout", 32'(bus.timeout), 0);
      check_eq("done_data", 32'(bus.tx_data), 32'(ebb));
      check_eq("done_grant", 32'(bus.grant_id), 32'(gg));
      ptr_m   = (gg + 1) % N;
      bus.req = '0;
   endtask

   initial begin
      n_checks     = 0;
      n_fails      = 0;
      ptr_m        = 0;
      bus.req      = '0;
      bus.req_data = '0;
      bus.tx_done  = 1'b0;
      reset        = 1'b1;
      for (int i = 0; i < N; i++) bytes_m[i] = 8'h00;
      #2;
      do_reset(2);

      // Single request from requester 2.
      bytes_m[2] = 8'hA5;
      start_xfer(4'b0100, g, eb);
      check_eq("single_grant", 32'(bus.grant_id), 2);
      check_eq("single_data", 32'(bus.tx_data), 32'hA5);
      finish_xfer(g, eb, 3);
      tick();
      check_eq("single_idle_busy", 32'(bus.busy), 0);

      // All four requesting continuously.
      do_reset(1);
      for (int i = 0; i < N; i++) bytes_m[i] = 8'(8'h10 + i);
      rr_exp = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         start_xfer(4'b1111, g, eb);
         check_eq("rr_grant", 32'(bus.grant_id), 32'(rr_exp[i]));
         finish_xfer(g, eb, int'($urandom_range(0, 4)));
      end

      // Pointer wrap after serving requester 3.
      do_reset(1);
      start_xfer(4'b1000, g, eb);
      check_eq("wrap_grant_a", 32'(bus.grant_id), 3);
      finish_xfer(g, eb, 1);
      start_xfer(4'b1001, g, eb);
      check_eq("wrap_grant_b", 32'(bus.grant_id), 0);
      finish_xfer(g, eb, 0);
      start_xfer(4'b1001, g, eb);
      check_eq("wrap_grant_c", 32'(bus.grant_id), 3);
      finish_xfer(g, eb, 2);

      // Reset in the middle of WAIT abandons the byte.
      start_xfer(4'b0100, g, eb);
      tick();
      do_reset(3);
      start_xfer(4'b1010, g, eb);
      check_eq("post_rst_grant", 32'(bus.grant_id), 1);
      finish_xfer(g, eb, 1);

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         logic [N-1:0] r;
         for (int i = 0; i < N; i++) bytes_m[i] = 8'($urandom);
         r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
         start_xfer(r, g, eb);
         if (g >= 0) finish_xfer(g, eb, int'($urandom_range(0, 6)));
      end

`ifdef UART_TX_TIMEOUT_EN
      // Watchdog expiry without tx_done.
      bytes_m[1] = 8'h3C;
      start_xfer(4'b0010, g, eb);
      bus.req = '0;
      for (int k = 1; k < 100; k++) begin
         tick();
         check_eq("wd_pending", 32'(bus.timeout), 0);
         check_eq("wd_busy", 32'(bus.busy), 1);
      end
      tick();
      check_eq("wd_timeout", 32'(bus.timeout), 1);
      check_eq("wd_done", 32'(bus.done), 0);
      check_eq("wd_busy_after", 32'(bus.busy), 0);
      ptr_m = (g + 1) % N;
      tick();
      check_eq("wd_pulse_end", 32'(bus.timeout), 0);
      // tx_done in the expiry cycle counts as completion.
      start_xfer(4'b0010, g, eb);
      finish_xfer(g, eb, 99);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
